// File: rtl/sample_capture_if.sv
// Readout stream interface for sample_capture.
// The capture block drives dataOut/validOut as master. The host-transfer logic answers with
// readyIn as slave. A transfer happens on any cycle with validOut && readyIn.
//   dataOut   SAMPLE_WIDTH  stored sample being offered
//   validOut  1             dataOut is valid
//   readyIn   1             downstream accepts dataOut
interface sample_capture_if #(
  parameter int unsigned SAMPLE_WIDTH = 8
) ();
  logic [SAMPLE_WIDTH-1:0] dataOut;
  logic                    validOut;
  logic                    readyIn;

  modport master (
    output dataOut,
    output validOut,
    input  readyIn
  );

  modport slave (
    input  dataOut,
    input  validOut,
    output readyIn
  );
endinterface

// File: rtl/sample_capture.sv
// sample_capture: trigger-and-store back end for the divided sample stream.
// The block keeps a circular pre-trigger history in on-chip RAM and watches for a masked
// trigger pattern. After the trigger it stores postCount more samples. It then streams the
// stored window out, oldest first, over out_if.
// Ports:
//   clock, reset         single clock; asynchronous active-high reset
//   arm                  pulse; starts a capture from IDLE and latches postCount
//   abort                pulse; returns to IDLE from any state, and has priority
//   dataIn, validIn      sample stream from the sampler
//   trigMask, trigValue  masked trigger compare
//   postCount            samples stored after the trigger sample
//   out_if (master)      readout stream: dataOut / validOut / readyIn
//   armed                state is ARMED or POST
//   triggered            state is POST or READOUT
//   done                 one-cycle pulse after the last readout transfer
// Optional feature: define SAMPLE_CAPTURE_TRIGGER_EDGE_EN to make the trigger also require a
// change on a masked bit relative to the previous valid sample.
module sample_capture #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    validIn,
  input  logic [SAMPLE_WIDTH-1:0] trigMask,
  input  logic [SAMPLE_WIDTH-1:0] trigValue,
  input  logic [DEPTH_LOG2-1:0]   postCount,
  sample_capture_if.master        out_if,
  output logic                    armed,
  output logic                    triggered,
  output logic                    done
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPost,
    StReadout
  } state_e;

  state_e                  state_q;
  ptr_t                    wr_ptr_q;
  ptr_t                    post_left_q;
  ptr_t                    rd_ptr_q;
  cnt_t                    fill_q;
  cnt_t                    rd_left_q;
  logic [SAMPLE_WIDTH-1:0] data_out_q;
  logic                    valid_out_q;
  logic                    armed_q;
  logic                    triggered_q;
  logic                    done_q;

  logic [SAMPLE_WIDTH-1:0] mem_q [Depth];

  logic capturing;
  logic store_en;
  logic level_hit;
  logic trig_hit;
  logic to_readout;
  logic rd_load;
  logic xfer;
  ptr_t wr_ptr_next;
  cnt_t fill_next;
  ptr_t oldest;

  assign capturing   = (state_q == StArmed) || (state_q == StPost);
  assign store_en    = capturing && validIn && !abort;
  assign level_hit   = ((dataIn ^ trigValue) & trigMask) == '0;
  assign wr_ptr_next = wr_ptr_q + ptr_t'(1);
  assign fill_next   = (fill_q == DepthCnt) ? fill_q : fill_q + cnt_t'(1);
  // Once the buffer has wrapped, the oldest sample sits at the next write slot.
  assign oldest      = (fill_next == DepthCnt) ? wr_ptr_next : '0;

`ifdef SAMPLE_CAPTURE_TRIGGER_EDGE_EN
  logic [SAMPLE_WIDTH-1:0] prev_q;
  logic                    prev_valid_q;

  // The first valid sample after arm has no predecessor, so it can never trigger.
  assign trig_hit = level_hit && prev_valid_q && (((dataIn ^ prev_q) & trigMask) != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if ((state_q == StIdle) && arm && !abort) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (store_en) begin
      prev_q       <= dataIn;
      prev_valid_q <= 1'b1;
    end
  end
`else
  assign trig_hit = level_hit;
`endif

  // This store completes the capture: a trigger with nothing left to record, or the last
  // post-trigger sample.
  assign to_readout = store_en &&
                      (((state_q == StArmed) && trig_hit && (post_left_q == '0)) ||
                       ((state_q == StPost) && (post_left_q == ptr_t'(1))));

  // Prefetch: refill the output register whenever it is empty or being drained.
  assign xfer    = valid_out_q && out_if.readyIn;
  assign rd_load = (state_q == StReadout) && (rd_left_q != '0) &&
                   (!valid_out_q || out_if.readyIn);

  always_ff @(posedge clock) begin
    if (store_en) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      post_left_q <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      rd_left_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= StIdle;
        valid_out_q <= 1'b0;
        armed_q     <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (arm) begin
              wr_ptr_q    <= '0;
              fill_q      <= '0;
              post_left_q <= postCount;
              state_q     <= StArmed;
              armed_q     <= 1'b1;
            end
          end
          StArmed, StPost: begin
            if (validIn) begin
              wr_ptr_q <= wr_ptr_next;
              fill_q   <= fill_next;
              if (state_q == StPost) begin
                post_left_q <= post_left_q - ptr_t'(1);
              end
              if (to_readout) begin
                state_q     <= StReadout;
                armed_q     <= 1'b0;
                triggered_q <= 1'b1;
                rd_ptr_q    <= oldest;
                rd_left_q   <= fill_next;
              end else if ((state_q == StArmed) && trig_hit) begin
                state_q     <= StPost;
                triggered_q <= 1'b1;
              end
            end
          end
          StReadout: begin
            if (rd_load) begin
              data_out_q  <= mem_q[rd_ptr_q];
              valid_out_q <= 1'b1;
              rd_ptr_q    <= rd_ptr_q + ptr_t'(1);
              rd_left_q   <= rd_left_q - cnt_t'(1);
            end else if (xfer) begin
              // Last sample accepted: nothing left to prefetch.
              valid_out_q <= 1'b0;
              state_q     <= StIdle;
              triggered_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign out_if.dataOut  = data_out_q;
  assign out_if.validOut = valid_out_q;
  assign armed           = armed_q;
  assign triggered       = triggered_q;
  assign done            = done_q;

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture (DEPTH_LOG2 = 4, SAMPLE_WIDTH = 8).
// The reference model records every strobed sample in a queue. It decides the trigger and the
// end of capture from the masked-compare rules. The expected readout window is the last
// min(n, 16) stored samples.
module tb_sample_capture;
  localparam int unsigned W     = 8;
  localparam int unsigned DL    = 4;
  localparam int unsigned Depth = 16;
`ifdef SAMPLE_CAPTURE_TRIGGER_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          arm;
  logic          abort;
  logic [W-1:0]  dataIn;
  logic          validIn;
  logic [W-1:0]  trigMask;
  logic [W-1:0]  trigValue;
  logic [DL-1:0] postCount;
  logic          armed;
  logic          triggered;
  logic          done;

  sample_capture_if #(.SAMPLE_WIDTH(W)) out_if ();

  sample_capture #(
    .SAMPLE_WIDTH(W),
    .DEPTH_LOG2  (DL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .arm      (arm),
    .abort    (abort),
    .dataIn   (dataIn),
    .validIn  (validIn),
    .trigMask (trigMask),
    .trigValue(trigValue),
    .postCount(postCount),
    .out_if   (out_if),
    .armed    (armed),
    .triggered(triggered),
    .done     (done)
  );

  always #5 clock = ~clock;

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [W-1:0] stored[$];
  logic [W-1:0] window[$];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arm with the given settings and feed samples until the model says capture is complete.
  // data_mode: 0 ramp (start + cycle), 1 random (value forced at force_at), 2 fixed sequence.
  // period: strobe every period cycles; 0 means random strobes.
  task automatic capture(input logic [W-1:0] mask, input logic [W-1:0] value,
                         input logic [DL-1:0] post, input int data_mode,
                         input logic [W-1:0] start, input int period, input int force_at,
                         output bit fin);
    int           c;
    int           post_rem;
    int           n;
    bit           fired;
    bit           have_prev;
    bit           hit;
    bit           v;
    logic [W-1:0] prev;
    logic [W-1:0] d;
    logic [W-1:0] seq [4];
    seq = '{8'h01, 8'h01, 8'h00, 8'h01};
    trigMask  = mask;
    trigValue = value;
    postCount = post;
    validIn   = 1'b0;
    arm       = 1'b1;
    step();
    arm = 1'b0;
    check("armed_after_arm", armed, 1);
    check("trig_after_arm", triggered, 0);
    stored.delete();
    fired     = 1'b0;
    have_prev = 1'b0;
    prev      = '0;
    post_rem  = int'(post);
    fin       = 1'b0;
    c         = 0;
    while (!fin && c < 400) begin
      if (period == 0) v = ($urandom_range(0, 1) == 1) || (c == force_at);
      else v = (c % period) == 0;
      case (data_mode)
        0:       d = start + W'(c);
        1:       d = (c == force_at) ? value : W'($urandom);
        default: d = seq[c % 4];
      endcase
      validIn = v;
      dataIn  = d;
      step();
      if (v) begin
        stored.push_back(d);
        if (!fired) begin
          hit = ((d ^ value) & mask) == '0;
          if (EdgeEn) hit = hit && have_prev && (((d ^ prev) & mask) != '0);
          have_prev = 1'b1;
          prev      = d;
          if (hit) begin
            fired = 1'b1;
            if (post == '0) fin = 1'b1;
          end
        end else begin
          post_rem--;
          if (post_rem == 0) fin = 1'b1;
        end
      end
      check("triggered_track", triggered, {31'b0, fired});
      check("armed_track", armed, {31'b0, !fin});
      c++;
    end
    validIn = 1'b0;
    check("capture_finished", {31'b0, fin}, 1);
    if (!fin) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
    end
    window.delete();
    n = stored.size();
    for (int i = (n > Depth) ? n - Depth : 0; i < n; i++) window.push_back(stored[i]);
  endtask

  // Drain the window. ready_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random.
  task automatic readout(input int ready_mode, input bit poke_arm, output int xfers);
    int           idx;
    int           cyc;
    bit           held;
    bit           r;
    logic [W-1:0] held_d;
    idx   = 0;
    cyc   = 0;
    held  = 1'b0;
    xfers = 0;
    check("vo_readout_entry", out_if.validOut, 0);
    out_if.readyIn = 1'b0;
    step();
    check("vo_first_latency", out_if.validOut, 1);
    while (idx < window.size() && cyc < 200) begin
      if (held) begin
        check("hold_valid", out_if.validOut, 1);
        check("hold_data", out_if.dataOut, held_d);
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = $urandom_range(0, 1) == 1;
      endcase
      out_if.readyIn = r;
      // Strobes during readout must not overwrite the buffer.
      validIn = 1'b1;
      dataIn  = W'($urandom);
      arm     = poke_arm && (cyc == 2);
      if (out_if.validOut && r) begin
        check("readout_data", out_if.dataOut, window[idx]);
        idx++;
        xfers++;
        held = 1'b0;
      end else if (out_if.validOut) begin
        held   = 1'b1;
        held_d = out_if.dataOut;
      end else begin
        held = 1'b0;
      end
      step();
      if (arm) check("arm_ignored_in_readout", armed, 0);
      arm = 1'b0;
      cyc++;
    end
    validIn        = 1'b0;
    out_if.readyIn = 1'b0;
    check("readout_count", idx, window.size());
    check("vo_after_last", out_if.validOut, 0);
    check("done_pulse", done, 1);
    check("armed_idle", armed, 0);
    check("trig_idle", triggered, 0);
    step();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    bit fin;
    int xfers;
    reset          = 1'b1;
    arm            = 1'b0;
    abort          = 1'b0;
    dataIn         = '0;
    validIn        = 1'b0;
    trigMask       = '0;
    trigValue      = '0;
    postCount      = '0;
    out_if.readyIn = 1'b0;
    #2;
    check("rst_dataOut", out_if.dataOut, 0);
    check("rst_validOut", out_if.validOut, 0);
    check("rst_armed", armed, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);
    #10;
    reset = 1'b0;
    step();
    // validIn in IDLE is ignored: no status change.
    validIn = 1'b1;
    step();
    validIn = 1'b0;
    check("idle_ignores_valid", armed, 0);

`ifndef SAMPLE_CAPTURE_TRIGGER_EDGE_EN
    // Immediate trigger on the first sample.
    capture(8'h00, 8'h00, 4'd3, 0, 8'h10, 1, -1, fin);
    if (fin) readout(0, 1'b0, xfers);

    // Wrapped pre-trigger history.
    capture(8'hFF, 8'h28, 4'd4, 0, 8'h00, 1, -1, fin);
    if (fin) readout(0, 1'b0, xfers);

    // Same capture under backpressure.
    capture(8'hFF, 8'h28, 4'd4, 0, 8'h00, 1, -1, fin);
    if (fin) begin
      readout(1, 1'b0, xfers);
      check("backpressure_xfers", xfers, 16);
    end

    // Abort in POST, together with an arm.
    trigMask  = 8'hFF;
    trigValue = 8'h28;
    postCount = 4'd4;
    arm       = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i <= 8'h29; i++) begin
      validIn = 1'b1;
      dataIn  = W'(i);
      step();
    end
    check("abort_pre_trig", triggered, 1);
    check("abort_pre_armed", armed, 1);
    abort   = 1'b1;
    arm     = 1'b1;
    dataIn  = 8'h2A;
    step();
    abort   = 1'b0;
    arm     = 1'b0;
    validIn = 1'b0;
    check("abort_armed", armed, 0);
    check("abort_triggered", triggered, 0);
    check("abort_validOut", out_if.validOut, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", done, 0);
      step();
    end

    // Asynchronous reset during readout.
    capture(8'hFF, 8'h28, 4'd4, 0, 8'h00, 1, -1, fin);
    out_if.readyIn = 1'b1;
    step();
    step();
    step();
    check("vo_before_reset", out_if.validOut, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_dataOut", out_if.dataOut, 0);
    check("async_rst_validOut", out_if.validOut, 0);
    check("async_rst_armed", armed, 0);
    check("async_rst_triggered", triggered, 0);
    check("async_rst_done", done, 0);
    #2;
    reset          = 1'b0;
    out_if.readyIn = 1'b0;
    step();

    // Sparse strobes, with arm poked during readout.
    capture(8'hFC, 8'h0C, 4'd2, 0, 8'h0A, 4, -1, fin);
    if (fin) readout(0, 1'b1, xfers);

    // Maximum post count, and a partially filled buffer.
    capture(8'hFF, 8'h05, 4'd15, 0, 8'h00, 1, -1, fin);
    if (fin) readout(0, 1'b0, xfers);
    capture(8'hFF, 8'h02, 4'd2, 0, 8'h00, 1, -1, fin);
    if (fin) readout(2, 1'b0, xfers);
`else
    // Edge-qualified trigger fires on the 4th sample, not the 1st.
    capture(8'h01, 8'h01, 4'd0, 2, 8'h00, 1, -1, fin);
    check("edge_trigger_index", stored.size(), 4);
    if (fin) readout(0, 1'b0, xfers);
`endif

    // Randomised captures.
    for (int t = 0; t < 8; t++) begin
      capture(W'($urandom), W'($urandom), DL'($urandom_range(0, 15)), 1, 8'h00, 0,
              $urandom_range(0, 40), fin);
      if (fin) readout(2, 1'b0, xfers);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
